// File: rtl/ac_pkg.sv
// Shared air-conditioning definitions: sequencer state encodings and default thresholds,
// reused by the sensor and display blocks.
package ac_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCool = 2'b01,
    StHeat = 2'b10,
    StRest = 2'b11
  } ac_state_e;

  localparam int unsigned DefaultLowTh  = 18;
  localparam int unsigned DefaultTarget = 20;
  localparam int unsigned DefaultHighTh = 22;

endpackage

// File: rtl/ac_timer.sv
// Loadable up-counter with synchronous clear, saturation at a run-time limit and a done flag
// raised while the count sits at the limit.
module ac_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (inc && (count_q < limit)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == limit);

endmodule

// File: rtl/ac_sequencer.sv
// Thermostat sequencer: hysteretic heat/cool requests with minimum-on time and a mandatory
// rest period between runs; outputs are pure decodes of the state register.
module ac_sequencer
  import ac_pkg::*;
#(
  parameter int unsigned TEMP_W  = 5,
  parameter int unsigned LOW_TH  = DefaultLowTh,
  parameter int unsigned TARGET  = DefaultTarget,
  parameter int unsigned HIGH_TH = DefaultHighTh,
  parameter int unsigned MIN_ON  = 8,
  parameter int unsigned LOCKOUT = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [TEMP_W-1:0] temperature,
  output logic              heating,
  output logic              cooling,
  output logic [1:0]        state
);

  if (!((LOW_TH < TARGET) && (TARGET < HIGH_TH))) begin : g_bad_thresholds
    $error("ac_sequencer: thresholds must satisfy LOW_TH < TARGET < HIGH_TH");
  end
  if ((HIGH_TH >> TEMP_W) != 0) begin : g_bad_temp_w
    $error("ac_sequencer: HIGH_TH does not fit in TEMP_W bits");
  end
  if ((MIN_ON < 1) || (LOCKOUT < 1)) begin : g_bad_times
    $error("ac_sequencer: MIN_ON and LOCKOUT must be at least 1");
  end
  if ((((MIN_ON - 1) >> CNT_W) != 0) || (((LOCKOUT - 1) >> CNT_W) != 0)) begin : g_bad_cnt_w
    $error("ac_sequencer: CNT_W too narrow for MIN_ON/LOCKOUT");
  end

  ac_state_e        state_q, state_d;
  logic             timer_clr;
  logic             timer_inc;
  logic             timer_done;
  logic [CNT_W-1:0] timer_limit;

  logic temp_low, temp_high, temp_ge_target, temp_le_target;

  assign temp_low       = (temperature <= TEMP_W'(LOW_TH));
  assign temp_high      = (temperature >= TEMP_W'(HIGH_TH));
  assign temp_ge_target = (temperature >= TEMP_W'(TARGET));
  assign temp_le_target = (temperature <= TEMP_W'(TARGET));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (enable && temp_low) begin
          state_d = StHeat;
        end else if (enable && temp_high) begin
          state_d = StCool;
        end
      end
      StHeat: begin
        if (timer_done && (temp_ge_target || !enable)) state_d = StRest;
      end
      StCool: begin
        if (timer_done && (temp_le_target || !enable)) state_d = StRest;
      end
      StRest: begin
        if (timer_done) state_d = StIdle;
      end
      // Unknown state recovers through the lockout so the plant is never short-cycled.
      default: state_d = StRest;
    endcase
  end

  always_comb begin
    heating = (state_q == StHeat);
    cooling = (state_q == StCool);
    state   = state_q;
  end

  // One timer serves every timed state; it restarts from zero on each state change.
  assign timer_clr   = (state_q == StIdle) || (state_d != state_q);
  assign timer_inc   = (state_q != StIdle);
  assign timer_limit = (state_q == StRest) ? CNT_W'(LOCKOUT - 1) : CNT_W'(MIN_ON - 1);

  ac_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .load    (1'b0),
    .load_val({CNT_W{1'b0}}),
    .inc     (timer_inc),
    .limit   (timer_limit),
    .done    (timer_done)
  );

endmodule

// File: tb/tb_ac_sequencer.sv
// Directed vector table plus hand-written reset and randomised property sequences for
// ac_sequencer at default parameters.
module tb_ac_sequencer;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_COOL = 2'b01;
  localparam logic [1:0] S_HEAT = 2'b10;
  localparam logic [1:0] S_REST = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [4:0] temperature;
  logic       heating;
  logic       cooling;
  logic [1:0] state;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic       en;
    logic [4:0] temp;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];

  ac_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .temperature(temperature),
    .heating    (heating),
    .cooling    (cooling),
    .state      (state)
  );

  always #5 clk = ~clk;

  function automatic void add(int n, logic en, logic [4:0] temp, logic [1:0] st);
    vec_t v;
    v.en   = en;
    v.temp = temp;
    v.st   = st;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [1:0] exp_st);
    logic exp_h, exp_c;
    exp_h = (exp_st == S_HEAT);
    exp_c = (exp_st == S_COOL);
    tests++;
    if (state !== exp_st || heating !== exp_h || cooling !== exp_c) begin
      failed++;
      $display("FAIL %s: got state=%b heating=%b cooling=%b, expected state=%b heating=%b cooling=%b",
               name, state, heating, cooling, exp_st, exp_h, exp_c);
    end
  endtask

  task automatic prop(string name, logic ok, int actual);
    tests++;
    if (!ok) begin
      failed++;
      $display("FAIL %s at %0t: value=%0d", name, $time, actual);
    end
  endtask

  initial begin
    // Idle hold at target
    add(50, 1, 20, S_IDLE);
    // Heat, temperature overshoots early, min-on honoured, rest, idle, then cool
    add(2, 1, 5, S_HEAT);
    add(6, 1, 25, S_HEAT);
    add(4, 1, 25, S_REST);
    add(1, 1, 25, S_IDLE);
    add(1, 1, 25, S_COOL);
    add(7, 1, 20, S_COOL);
    add(4, 1, 20, S_REST);
    add(1, 1, 20, S_IDLE);
    // Cool from 31 for 10 cycles, then 19 ends it straight away
    add(10, 1, 31, S_COOL);
    add(4, 1, 19, S_REST);
    add(3, 1, 19, S_IDLE);
    // Threshold boundaries
    add(1, 1, 21, S_IDLE);
    add(1, 0, 0, S_IDLE);
    add(1, 1, 18, S_HEAT);
    add(9, 1, 19, S_HEAT);
    add(4, 1, 20, S_REST);
    add(1, 1, 22, S_IDLE);
    add(1, 1, 22, S_COOL);
    add(9, 1, 21, S_COOL);
    add(4, 1, 20, S_REST);
    add(1, 1, 0, S_IDLE);
    add(1, 1, 0, S_HEAT);
    add(7, 0, 0, S_HEAT);
    add(4, 0, 0, S_REST);
    add(1, 0, 0, S_IDLE);
    add(1, 0, 31, S_IDLE);
    // Enable drops during the third cooling cycle
    add(2, 1, 31, S_COOL);
    add(6, 0, 31, S_COOL);
    add(4, 0, 31, S_REST);
    add(3, 0, 31, S_IDLE);

    rst_n       = 1'b0;
    enable      = 1'b0;
    temperature = 5'd20;
    #12;
    check("reset", S_IDLE);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      enable      = vecs[i].en;
      temperature = vecs[i].temp;
      tick();
      check($sformatf("vec%0d", i), vecs[i].st);
    end

    // Asynchronous reset in the middle of a heat run
    enable      = 1'b1;
    temperature = 5'd5;
    tick();
    check("rst_pre0", S_HEAT);
    tick();
    check("rst_pre1", S_HEAT);
    #3 rst_n = 1'b0;
    #1 check("rst_async", S_IDLE);
    tick();
    check("rst_held", S_IDLE);
    #3 rst_n = 1'b1;
    tick();
    check("rst_reheat", S_HEAT);
    temperature = 5'd25;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("rst_run%0d", i), S_HEAT);
    end
    tick();
    check("rst_rest", S_REST);

    // Randomised run with safety properties
    #3 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    begin
      logic prev_h = 1'b0, prev_c = 1'b0, last_heat = 1'b0, rest_seen = 1'b1, first = 1'b1;
      int   run_len = 0, low_len = 0;
      for (int i = 0; i < 10000; i++) begin
        enable      = ($urandom_range(0, 7) != 0);
        temperature = 5'($urandom_range(0, 31));
        tick();
        prop("both_on", !(heating && cooling), i);
        if ((heating || cooling) && !(prev_h || prev_c)) begin
          if (!first) begin
            prop("low_gap", low_len >= 4, low_len);
            if (cooling && last_heat) prop("heat_to_cool_rest", rest_seen, i);
          end
          first     = 1'b0;
          run_len   = 1;
          rest_seen = 1'b0;
        end else if (heating || cooling) begin
          prop("mode_switch", heating == prev_h, i);
          run_len++;
        end else if (prev_h || prev_c) begin
          prop("min_on", run_len >= 8, run_len);
          last_heat = prev_h;
          low_len   = 1;
        end else begin
          low_len++;
        end
        if (state == S_REST) rest_seen = 1'b1;
        prev_h = heating;
        prev_c = cooling;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
